// File: rtl/tva_precision_pkg.sv
// Shared precision-code encoding and selector FSM states; the AV multiply
// stage imports the same code constants so both sides agree on meaning.
package tva_precision_pkg;

  typedef logic [3:0] prec_code_t;

  localparam prec_code_t PREC_INT4 = 4'd0;
  localparam prec_code_t PREC_INT8 = 4'd1;
  localparam prec_code_t PREC_FP16 = 4'd2;

  localparam int KEY_W = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SCAN,
    S_CLASSIFY,
    S_DONE
  } sel_state_t;

  // The high threshold wins even when thr_lo > thr_hi, and ties round up.
  function automatic prec_code_t classify_peak(input logic [KEY_W-1:0] peak,
                                               input logic [KEY_W-1:0] hi_key,
                                               input logic [KEY_W-1:0] lo_key);
    if (peak >= hi_key) return PREC_FP16;
    if (peak >= lo_key) return PREC_INT8;
    return PREC_INT4;
  endfunction

endpackage

// File: rtl/fp16_mag_key.sv
// Maps an FP16 value to a 15-bit key whose unsigned order matches magnitude
// order for non-negative values; negatives rank as zero, Inf/NaN saturate.
module fp16_mag_key
  import tva_precision_pkg::*;
(
  input  logic [15:0]      value,
  output logic [KEY_W-1:0] key
);

  always_comb begin
    key = value[14:0];
    if (value[15]) begin
      key = '0;
    end else if (value[14:10] == 5'h1F) begin
      key = '1;
    end
  end

endmodule

// File: rtl/token_precision_selector.sv
// Scans the softmax output one query row per cycle, tracks each key token's
// peak magnitude, then classifies every token into an INT4/INT8/FP16 code.
module token_precision_selector
  import tva_precision_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int L          = 8,
  parameter int N          = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [DATA_WIDTH*L*N*L-1:0]    A_in,
  input  logic [15:0]                    thr_hi,
  input  logic [15:0]                    thr_lo,
  output logic                           busy,
  output logic                           done,
  output logic                           out_valid,
  output logic [3:0]                     token_precision [L-1:0]
);

  localparam int CNT_W = (L > 1) ? $clog2(L) : 1;

  sel_state_t       state;
  logic [CNT_W-1:0] row_cnt;
  logic [KEY_W-1:0] peak     [L];
  logic [KEY_W-1:0] hi_key;
  logic [KEY_W-1:0] lo_key;
  logic [KEY_W-1:0] hi_key_c;
  logic [KEY_W-1:0] lo_key_c;
  logic [KEY_W-1:0] elem_key [N][L];
  logic [KEY_W-1:0] row_max  [L];
  logic [DATA_WIDTH-1:0] a_mem [L][N][L];

  assign busy = (state != S_IDLE);

  // Snapshot of A so later changes on A_in cannot disturb a pass in flight.
  always_ff @(posedge clk) begin
    if (state == S_LOAD) begin
      for (int l = 0; l < L; l++) begin
        for (int n = 0; n < N; n++) begin
          for (int c = 0; c < L; c++) begin
            a_mem[l][n][c] <= A_in[((l*N*L) + (n*L) + c)*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

  fp16_mag_key u_hi_key (.value(thr_hi), .key(hi_key_c));
  fp16_mag_key u_lo_key (.value(thr_lo), .key(lo_key_c));

  for (genvar gn = 0; gn < N; gn++) begin : g_head
    for (genvar gc = 0; gc < L; gc++) begin : g_col
      fp16_mag_key u_key (.value(a_mem[row_cnt][gn][gc]), .key(elem_key[gn][gc]));
    end
  end

  always_comb begin
    for (int c = 0; c < L; c++) begin
      row_max[c] = '0;
      for (int n = 0; n < N; n++) begin
        if (elem_key[n][c] > row_max[c]) row_max[c] = elem_key[n][c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      row_cnt   <= '0;
      hi_key    <= '0;
      lo_key    <= '0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      for (int i = 0; i < L; i++) begin
        peak[i]            <= '0;
        token_precision[i] <= PREC_INT4;
      end
    end else begin
      done      <= 1'b0;
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) state <= S_LOAD;
        end
        S_LOAD: begin
          hi_key  <= hi_key_c;
          lo_key  <= lo_key_c;
          row_cnt <= '0;
          for (int i = 0; i < L; i++) peak[i] <= '0;
          state <= S_SCAN;
        end
        S_SCAN: begin
          for (int i = 0; i < L; i++) begin
            if (row_max[i] > peak[i]) peak[i] <= row_max[i];
          end
          if (row_cnt == CNT_W'(L-1)) begin
            row_cnt <= '0;
            state   <= S_CLASSIFY;
          end else begin
            row_cnt <= row_cnt + CNT_W'(1);
          end
        end
        S_CLASSIFY: begin
          for (int i = 0; i < L; i++) begin
            token_precision[i] <= classify_peak(peak[i], hi_key, lo_key);
          end
          state <= S_DONE;
        end
        S_DONE: begin
          done      <= 1'b1;
          out_valid <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
